man_rx_frame_ctrl: RTL and testbench

- Frame-level receive controller that sequences the Manchester decoder. It enables and clears the decoder, then hunts for a sync byte in the decoded bit stream.
- It then assembles a length byte, payload bytes and an XOR checksum. Payload bytes go out over a valid/ready byte interface, and the block reports frame completion or a coded error.
- It sits between the Manchester decoder (bit level) and the downstream byte consumer.

---
 rtl/man_rx_frame_ctrl_if.sv | 23 ++
 rtl/man_rx_frame_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_man_rx_frame_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/man_rx_frame_ctrl_if.sv
// Bit stream from the Manchester decoder and payload byte stream to the consumer.
interface man_rx_frame_ctrl_if;
  logic       dec_en;
  logic       dec_clr;
  logic       bit_vld;
  logic       bit_val;
  logic       bit_err;
  logic [7:0] byte_data;
  logic       byte_vld;
  logic       byte_rdy;

  // Frame controller side: drives the decoder controls and the payload bytes.
  modport master (
    output dec_en, dec_clr, byte_data, byte_vld,
    input  bit_vld, bit_val, bit_err, byte_rdy
  );

  // Decoder / consumer side.
  modport slave (
    input  dec_en, dec_clr, byte_data, byte_vld,
    output bit_vld, bit_val, bit_err, byte_rdy
  );
endinterface

// File: rtl/man_rx_frame_ctrl.sv
// Manchester receive frame controller: sync hunt, length, payload, XOR checksum.
// Payload bytes are handed out on a valid/ready interface; completion and
// abort reasons are reported as one-cycle pulses plus a sticky error code.
module man_rx_frame_ctrl #(
  parameter logic [7:0]  SYNC_PATTERN = 8'hD5,
  parameter int unsigned MAX_LEN      = 15,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                clk,
  input  logic                rst,
  man_rx_frame_ctrl_if.master bus,
  output logic [7:0]          frame_len,
  output logic                frame_done,
  output logic                frame_err,
  output logic [2:0]          err_code,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_HUNT = 3'd1, S_LEN = 3'd2, S_DATA = 3'd3,
    S_CSUM = 3'd4, S_DONE = 3'd5, S_ERR = 3'd6
  } state_t;

  localparam logic [7:0] MAX_LEN_C = 8'(MAX_LEN);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [2:0] E_CODE    = 3'd1;
  localparam logic [2:0] E_LEN     = 3'd2;
  localparam logic [2:0] E_OVR     = 3'd3;
  localparam logic [2:0] E_CSUM    = 3'd4;
  localparam logic [2:0] E_TMO     = 3'd5;

  // Running XOR checksum accumulation.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t     state_r, state_s;
  logic [6:0] shift_r, shift_s;       // seven bits of history; with the new bit they form a byte
  logic [2:0] bit_cnt_r, bit_cnt_s;
  logic [7:0] csum_r, csum_s;
  logic [7:0] tmo_r, tmo_s;
  logic [7:0] rem_r, rem_s;
  logic       csum_bad_r, csum_bad_s;
  logic [7:0] data_r, data_s;
  logic       vld_r, vld_s;
  logic [7:0] len_r, len_s;
  logic [2:0] code_r, code_s;
  logic       done_r, done_s;
  logic       dec_en_r, dec_clr_r, err_r, busy_r;

  logic       take_s;
  logic       byte_done_s;
  logic [7:0] shifted_s;
  logic [7:0] tmo_inc_s;

  assign bus.dec_en    = dec_en_r;
  assign bus.dec_clr   = dec_clr_r;
  assign bus.byte_data = data_r;
  assign bus.byte_vld  = vld_r;
  assign frame_len     = len_r;
  assign frame_done    = done_r;
  assign frame_err     = err_r;
  assign err_code      = code_r;
  assign busy          = busy_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    bit_cnt_s   = bit_cnt_r;
    csum_s      = csum_r;
    tmo_s       = tmo_r;
    rem_s       = rem_r;
    csum_bad_s  = csum_bad_r;
    data_s      = data_r;
    len_s       = len_r;
    code_s      = code_r;
    done_s      = 1'b0;
    take_s      = bus.bit_vld && !bus.bit_err;
    shifted_s   = {shift_r, bus.bit_val};
    byte_done_s = take_s && (bit_cnt_r == 3'd7);
    tmo_inc_s   = bus.bit_vld ? 8'd0 : (tmo_r + 8'd1);
    // A pending byte is dropped from valid once the consumer takes it.
    if (vld_r && bus.byte_rdy) begin
      vld_s = 1'b0;
    end else begin
      vld_s = vld_r;
    end

    case (state_r)
      S_IDLE: begin
        // Stale bits from the previous frame must not seed a false sync.
        shift_s = 7'd0;
        if (dec_clr_r) begin
          state_s = S_HUNT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_HUNT: begin
        if (bus.bit_vld) begin
          shift_s = shifted_s[6:0];
          if (shifted_s == SYNC_PATTERN) begin
            state_s    = S_LEN;
            bit_cnt_s  = 3'd0;
            csum_s     = 8'd0;
            code_s     = 3'd0;
            tmo_s      = 8'd0;
            csum_bad_s = 1'b0;
          end else begin
            state_s = S_HUNT;
          end
        end else begin
          state_s = S_HUNT;
        end
      end
      S_LEN, S_DATA, S_CSUM: begin
        tmo_s = tmo_inc_s;
        if (take_s) begin
          shift_s   = shifted_s[6:0];
          bit_cnt_s = bit_cnt_r + 3'd1;
        end else begin
          bit_cnt_s = bit_cnt_r;
        end
        if (bus.bit_err) begin
          state_s = S_ERR;
          code_s  = E_CODE;
          vld_s   = 1'b0;
        end else if (tmo_inc_s == TIMEOUT_C) begin
          state_s = S_ERR;
          code_s  = E_TMO;
          vld_s   = 1'b0;
        end else if (byte_done_s) begin
          case (state_r)
            S_LEN: begin
              len_s = shifted_s;
              if ((shifted_s == 8'd0) || (shifted_s > MAX_LEN_C)) begin
                state_s = S_ERR;
                code_s  = E_LEN;
                vld_s   = 1'b0;
              end else begin
                state_s = S_DATA;
                rem_s   = shifted_s;
              end
            end
            S_DATA: begin
              if (vld_r && !bus.byte_rdy) begin
                state_s = S_ERR;
                code_s  = E_OVR;
                vld_s   = 1'b0;
              end else begin
                data_s  = shifted_s;
                vld_s   = 1'b1;
                csum_s  = csum_fold(csum_r, shifted_s);
                rem_s   = rem_r - 8'd1;
                state_s = (rem_r == 8'd1) ? S_CSUM : S_DATA;
              end
            end
            S_CSUM: begin
              // Mismatch still drains the pending byte through DONE before aborting.
              state_s    = S_DONE;
              csum_bad_s = (shifted_s != csum_r);
            end
            default: state_s = S_IDLE;
          endcase
        end else begin
          state_s = state_r;
        end
      end
      S_DONE: begin
        if (done_r) begin
          state_s = S_IDLE;
        end else if (!vld_r || bus.byte_rdy) begin
          if (csum_bad_r) begin
            state_s = S_ERR;
            code_s  = E_CSUM;
          end else begin
            state_s = S_DONE;
            done_s  = 1'b1;
          end
        end else begin
          state_s = S_DONE;
        end
      end
      S_ERR:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, all aligned with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r    <= 7'd0;
      bit_cnt_r  <= 3'd0;
      csum_r     <= 8'd0;
      tmo_r      <= 8'd0;
      rem_r      <= 8'd0;
      csum_bad_r <= 1'b0;
      data_r     <= 8'd0;
      vld_r      <= 1'b0;
      len_r      <= 8'd0;
      code_r     <= 3'd0;
      done_r     <= 1'b0;
      dec_en_r   <= 1'b0;
      dec_clr_r  <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      shift_r    <= shift_s;
      bit_cnt_r  <= bit_cnt_s;
      csum_r     <= csum_s;
      tmo_r      <= tmo_s;
      rem_r      <= rem_s;
      csum_bad_r <= csum_bad_s;
      data_r     <= data_s;
      vld_r      <= vld_s;
      len_r      <= len_s;
      code_r     <= code_s;
      done_r     <= done_s;
      dec_en_r   <= (state_s inside {S_HUNT, S_LEN, S_DATA, S_CSUM});
      dec_clr_r  <= (state_s == S_IDLE);
      err_r      <= (state_s == S_ERR);
      busy_r     <= (state_s inside {S_LEN, S_DATA, S_CSUM, S_DONE});
    end
  end

endmodule

// File: tb/tb_man_rx_frame_ctrl.sv
// Directed bench for man_rx_frame_ctrl: a table of whole frames plus
// hand-written sequences for overrun, code violation, timeout, hunt and reset.
module tb_man_rx_frame_ctrl;

  logic clk;
  logic rst;
  logic [7:0] frame_len;
  logic frame_done;
  logic frame_err;
  logic [2:0] err_code;
  logic busy;

  man_rx_frame_ctrl_if bus ();

  man_rx_frame_ctrl #(
    .SYNC_PATTERN(8'hD5), .MAX_LEN(15), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .frame_len(frame_len), .frame_done(frame_done), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [143:0] bytes;     // frame bytes, first byte in the top bits
    int           nbytes;
    int           exp_done;
    int           exp_err;
    logic [2:0]   exp_code;
    logic [7:0]   exp_len;
    int           exp_nout;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Monitor state (written only by the monitor process).
  int         n_done = 0;
  int         n_errp = 0;
  int         n_unstable = 0;
  logic [7:0] got_q[$];
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data = 8'd0;

  // Sample outputs on the falling edge: pulses, accepted bytes, data stability.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (frame_done) n_done = n_done + 1;
      if (frame_err) n_errp = n_errp + 1;
      if (bus.byte_vld && bus.byte_rdy) got_q.push_back(bus.byte_data);
      if (hold_prev && bus.byte_vld && (bus.byte_data !== prev_data)) n_unstable = n_unstable + 1;
      hold_prev = bus.byte_vld && !bus.byte_rdy;
      prev_data = bus.byte_data;
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    bus.bit_vld = 1'b1;
    bus.bit_val = v;
    tick();
    bus.bit_vld = 1'b0;
    bus.bit_val = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic wait_hunt(input string nm);
    int c;
    c = 0;
    while (!(bus.dec_en === 1'b1 && busy === 1'b0) && c < 40) begin
      tick();
      c++;
    end
    check({nm, "_hunt"}, 32'(bus.dec_en === 1'b1 && busy === 1'b0), 32'd1);
  endtask

  task automatic wait_end(input string nm, input int d0, input int e0);
    int c;
    c = 0;
    while (n_done == d0 && n_errp == e0 && c < 300) begin
      tick();
      c++;
    end
    check({nm, "_ended"}, 32'(n_done != d0 || n_errp != e0), 32'd1);
    repeat (3) tick();
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.dec_en, bus.dec_clr, bus.byte_data, bus.byte_vld, frame_len,
                frame_done, frame_err, err_code, busy});
  endfunction

  vec_t vecs[6];

  initial begin
    int d0, e0, q0;
    string nm;

    // Frame table: bytes, count, done, err, code, len, delivered bytes.
    vecs[0] = '{{8'hD5, 8'h02, 8'hA5, 8'h3C, 8'h98, {13{8'h00}}}, 5, 0, 1, 3'd4, 8'h02, 2};
    vecs[1] = '{{8'hD5, 8'h02, 8'hA5, 8'h3C, 8'h99, {13{8'h00}}}, 5, 1, 0, 3'd0, 8'h02, 2};
    vecs[2] = '{{8'hD5, 8'h00, {16{8'h00}}}, 2, 0, 1, 3'd2, 8'h00, 0};
    vecs[3] = '{{8'hD5, 8'h10, {16{8'h00}}}, 2, 0, 1, 3'd2, 8'h10, 0};
    vecs[4] = '{{8'hD5, 8'h01, 8'h7E, 8'h7E, {14{8'h00}}}, 4, 1, 0, 3'd0, 8'h01, 1};
    // Longest legal frame: payload 01..0F, XOR of 1..15 is 00.
    vecs[5] = '{144'd0, 18, 1, 0, 3'd0, 8'h0F, 15};
    vecs[5].bytes[143 -: 8] = 8'hD5;
    vecs[5].bytes[135 -: 8] = 8'h0F;
    for (int k = 1; k <= 15; k++) vecs[5].bytes[143 - 8 * (k + 1) -: 8] = 8'(k);
    vecs[5].bytes[7:0] = 8'h00;

    rst = 1'b1;
    bus.bit_vld = 1'b0;
    bus.bit_val = 1'b0;
    bus.bit_err = 1'b0;
    bus.byte_rdy = 1'b1;
    repeat (3) tick();
    check("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      nm = $sformatf("v%0d", i);
      wait_hunt(nm);
      d0 = n_done; e0 = n_errp; q0 = got_q.size();
      for (int k = 0; k < vecs[i].nbytes; k++) send_byte(vecs[i].bytes[143 - 8 * k -: 8]);
      wait_end(nm, d0, e0);
      check({nm, "_done"}, 32'(n_done - d0), 32'(vecs[i].exp_done));
      check({nm, "_err"}, 32'(n_errp - e0), 32'(vecs[i].exp_err));
      check({nm, "_code"}, 32'(err_code), 32'(vecs[i].exp_code));
      check({nm, "_len"}, 32'(frame_len), 32'(vecs[i].exp_len));
      check({nm, "_nout"}, 32'(got_q.size() - q0), 32'(vecs[i].exp_nout));
      for (int k = 0; k < vecs[i].exp_nout; k++)
        if (q0 + k < got_q.size())
          check($sformatf("%s_data%0d", nm, k), 32'(got_q[q0 + k]), 32'(vecs[i].bytes[143 - 8 * (k + 2) -: 8]));
    end

    // Overrun: consumer stalled, A5 held, 3C completion aborts.
    wait_hunt("ovr");
    d0 = n_done; e0 = n_errp; q0 = got_q.size();
    bus.byte_rdy = 1'b0;
    send_byte(8'hD5); send_byte(8'h02); send_byte(8'hA5);
    repeat (2) tick();
    check("ovr_hold_vld", 32'(bus.byte_vld), 32'd1);
    check("ovr_hold_data", 32'(bus.byte_data), 32'hA5);
    send_byte(8'h3C);
    wait_end("ovr", d0, e0);
    check("ovr_code", 32'(err_code), 32'd3);
    check("ovr_vld", 32'(bus.byte_vld), 32'd0);
    check("ovr_nout", 32'(got_q.size() - q0), 32'd0);
    bus.byte_rdy = 1'b1;

    // Acceptance on the exact completion cycle is not an overrun.
    wait_hunt("ovr_edge");
    d0 = n_done; e0 = n_errp; q0 = got_q.size();
    bus.byte_rdy = 1'b0;
    send_byte(8'hD5); send_byte(8'h02); send_byte(8'hA5);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h3C >> i));
    bus.byte_rdy = 1'b1;
    send_bit(1'b0);
    send_byte(8'h99);
    wait_end("ovr_edge", d0, e0);
    check("ovr_edge_done", 32'(n_done - d0), 32'd1);
    check("ovr_edge_err", 32'(n_errp - e0), 32'd0);
    check("ovr_edge_nout", 32'(got_q.size() - q0), 32'd2);
    if (got_q.size() - q0 == 2) begin
      check("ovr_edge_b0", 32'(got_q[q0]), 32'hA5);
      check("ovr_edge_b1", 32'(got_q[q0 + 1]), 32'h3C);
    end

    // Code violation after three payload bits.
    wait_hunt("cv");
    d0 = n_done; e0 = n_errp;
    send_byte(8'hD5); send_byte(8'h02);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    bus.bit_err = 1'b1; tick(); bus.bit_err = 1'b0;
    wait_end("cv", d0, e0);
    check("cv_code", 32'(err_code), 32'd1);
    check("cv_vld", 32'(bus.byte_vld), 32'd0);
    check("cv_err", 32'(n_errp - e0), 32'd1);

    // Bit and code violation together: the error wins.
    wait_hunt("cvb");
    d0 = n_done; e0 = n_errp;
    send_byte(8'hD5); send_byte(8'h02);
    bus.bit_err = 1'b1; bus.bit_vld = 1'b1; bus.bit_val = 1'b1;
    tick();
    bus.bit_err = 1'b0; bus.bit_vld = 1'b0; bus.bit_val = 1'b0;
    wait_end("cvb", d0, e0);
    check("cvb_code", 32'(err_code), 32'd1);

    // Timeout: stall after the length byte.
    wait_hunt("tmo");
    d0 = n_done; e0 = n_errp;
    send_byte(8'hD5); send_byte(8'h02);
    repeat (60) tick();
    check("tmo_early_err", 32'(n_errp - e0), 32'd0);
    check("tmo_early_busy", 32'(busy), 32'd1);
    wait_end("tmo", d0, e0);
    check("tmo_code", 32'(err_code), 32'd5);

    // Hunt with overlap: EA then one more 1 forms D5 at the ninth bit.
    wait_hunt("hunt");
    d0 = n_done; e0 = n_errp;
    send_byte(8'hEA);
    check("hunt_no_sync", 32'(busy), 32'd0);
    send_bit(1'b1);
    check("hunt_sync", 32'(busy), 32'd1);
    send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7E);
    wait_end("hunt", d0, e0);
    check("hunt_done", 32'(n_done - d0), 32'd1);

    // Reset in the middle of DATA.
    wait_hunt("rst");
    bus.byte_rdy = 1'b0;
    send_byte(8'hD5); send_byte(8'h02); send_byte(8'hA5);
    tick();
    check("rst_pre_vld", 32'(bus.byte_vld), 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_outs", all_outs(), 32'd0);
    bus.byte_rdy = 1'b1;
    tick();
    rst = 1'b0;
    begin
      int c;
      c = 0;
      while (bus.dec_clr !== 1'b1 && c < 5) begin
        tick();
        c++;
      end
    end
    check("rst_clr", 32'(bus.dec_clr), 32'd1);
    check("rst_clr_en", 32'(bus.dec_en), 32'd0);
    tick();
    check("rst_hunt_clr", 32'(bus.dec_clr), 32'd0);
    check("rst_hunt_en", 32'(bus.dec_en), 32'd1);

    check("data_stable", 32'(n_unstable), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
